// File: rtl/user_id_pkg.sv
// Shared types and constants for the user project ID serial readout.
package user_id_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Requester indices into req/gnt/done.
  localparam bit [0:0] REQ_MGMT = 1'b0;
  localparam bit [0:0] REQ_SPI  = 1'b1;

endpackage

// File: rtl/user_id_bit_timer.sv
// Bit-period timer: tick is high during the last system clock of each
// DIV-cycle serial bit period.
module user_id_bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (enable) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // tick is registered so it lines up with the cycle where cnt == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= enable && !clear && (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/user_id_reader.sv
// Arbitrated serial readout of the tie-cell user project ID with a
// capture/recheck stability test.
module user_id_reader
  import user_id_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned WIDTH = 32
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] mask_rev,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_strobe,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] id_word,
  output logic             err
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             prio;
  logic [1:0]       pick;
  logic             held;
  logic             tick;
  logic             tmr_clear;
  logic             tmr_enable;

  assign held       = |(req & gnt);
  assign tmr_enable = (state == SHIFT);
  assign tmr_clear  = (state != SHIFT);

  // Round-robin pick: prio names the requester that wins a tie.
  always_comb begin
    pick = '0;
    if (req[REQ_MGMT] && req[REQ_SPI]) begin
      pick[prio] = 1'b1;
    end else if (req[REQ_MGMT]) begin
      pick[REQ_MGMT] = 1'b1;
    end else if (req[REQ_SPI]) begin
      pick[REQ_SPI] = 1'b1;
    end
  end

  user_id_bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .tick  (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      ser_out    <= 1'b0;
      ser_strobe <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
      id_word    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      prio       <= REQ_MGMT;
    end else begin
      ser_strobe <= 1'b0;
      done       <= '0;
      // Losing the granted request abandons the transfer silently.
      if ((state inside {LOAD, SHIFT, CHECK}) && !held) begin
        state   <= IDLE;
        gnt     <= '0;
        busy    <= 1'b0;
        ser_out <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (|req) begin
              gnt   <= pick;
              busy  <= 1'b1;
              prio  <= pick[REQ_MGMT] ? REQ_SPI : REQ_MGMT;
              state <= LOAD;
            end
          end
          LOAD: begin
            shreg      <= mask_rev;
            id_word    <= mask_rev;
            ser_out    <= mask_rev[WIDTH-1];
            ser_strobe <= 1'b1;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (tick) begin
              if (bit_cnt == LAST_BIT) begin
                ser_out <= 1'b0;
                state   <= CHECK;
              end else begin
                bit_cnt    <= bit_cnt + BW'(1);
                ser_out    <= shreg[WIDTH-2];
                shreg      <= shreg << 1;
                ser_strobe <= 1'b1;
              end
            end
          end
          CHECK: begin
            // A different value now than at LOAD means the ID is unstable.
            if (mask_rev != id_word) begin
              err <= 1'b1;
            end
            done  <= gnt;
            state <= DONE;
          end
          DONE: begin
            gnt     <= '0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_id_reader.sv
// Bench for user_id_reader: three instances (DIV 4, 2, 255) checked every
// cycle against a transfer-timeline model, plus directed literal checks.
module tb_user_id_reader;

  localparam int unsigned W = 32;
  localparam int N = 3;
  localparam int BOUND = 9000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]   req  [N];
  logic [W-1:0] mask [N];
  logic [1:0]   gnt  [N];
  logic [1:0]   done [N];
  logic         busy [N];
  logic         ser  [N];
  logic         stb  [N];
  logic         err  [N];
  logic [W-1:0] idw  [N];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 4 : ((g == 1) ? 2 : 255);
    user_id_reader #(.DIV(D), .WIDTH(W)) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .mask_rev  (mask[g]),
      .req       (req[g]),
      .gnt       (gnt[g]),
      .busy      (busy[g]),
      .ser_out   (ser[g]),
      .ser_strobe(stb[g]),
      .done      (done[g]),
      .id_word   (idw[g]),
      .err       (err[g])
    );
  end

  function automatic int div_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 255);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model: a transfer is a timeline position k (0 = load cycle, 1..W*D = serial
  // bits, W*D+1 = recheck, W*D+2 = completion) rather than a state machine.
  bit         m_act  [N];
  int         m_k    [N];
  bit [1:0]   m_g    [N];
  int         m_prio [N];
  bit [W-1:0] m_word [N];
  bit [W-1:0] m_id   [N];
  bit         m_err  [N];

  task automatic model_step(input int i);
    int wd;
    wd = int'(W) * div_of(i);
    if (rst) begin
      m_act[i] = 0; m_k[i] = 0; m_g[i] = 0; m_prio[i] = 0;
      m_word[i] = '0; m_id[i] = '0; m_err[i] = 0;
    end else if (!m_act[i]) begin
      if (req[i] != 2'b00) begin
        if (req[i] == 2'b11) m_g[i] = (m_prio[i] == 0) ? 2'b01 : 2'b10;
        else m_g[i] = req[i];
        m_prio[i] = (m_g[i] == 2'b01) ? 1 : 0;
        m_act[i] = 1;
        m_k[i] = 0;
      end
    end else if (m_k[i] <= wd + 1 && (req[i] & m_g[i]) == 2'b00) begin
      m_act[i] = 0;
    end else begin
      if (m_k[i] == 0) begin
        m_word[i] = mask[i];
        m_id[i] = mask[i];
      end
      if (m_k[i] == wd + 1 && mask[i] != m_id[i]) m_err[i] = 1;
      m_k[i]++;
      if (m_k[i] == wd + 3) m_act[i] = 0;
    end
  endtask

  function automatic logic [39:0] exp_vec(int i);
    int d = div_of(i);
    int wd = int'(W) * d;
    logic [1:0] eg = 2'b00, ed = 2'b00;
    logic eb = 1'b0, es = 1'b0, est = 1'b0;
    if (m_act[i]) begin
      eg = m_g[i];
      eb = 1'b1;
      if (m_k[i] >= 1 && m_k[i] <= wd) begin
        es = m_word[i][int'(W) - 1 - (m_k[i] - 1) / d];
        est = ((m_k[i] - 1) % d) == 0;
      end
      if (m_k[i] == wd + 2) ed = m_g[i];
    end
    return {eg, eb, es, est, ed, m_id[i], m_err[i]};
  endfunction

  function automatic logic [39:0] dut_vec(int i);
    return {gnt[i], busy[i], ser[i], stb[i], done[i], idw[i], err[i]};
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("cycle_dut%0d", i), 64'(dut_vec(i)), 64'(exp_vec(i)));
  end

  // Waits for a grant, then follows the transfer to its done pulse and one
  // cycle beyond; lat counts granted cycles up to and including done.
  task automatic run_xfer(input int i, output logic [1:0] g, output int lat,
                          output logic [W-1:0] bits, output int nb, output int minh,
                          output int maxh, output logic [1:0] done_v,
                          output logic err_v, output bit ok);
    int t, since;
    g = 0; lat = 0; bits = 0; nb = 0; minh = 1 << 30; maxh = 0;
    done_v = 0; err_v = 0; ok = 0; since = -1; t = 0;
    while (gnt[i] == 2'b00 && t < 20) begin tick(); t++; end
    if (gnt[i] == 2'b00) return;
    g = gnt[i];
    t = 0;
    while (t < BOUND) begin
      lat++;
      if (since >= 0) since++;
      if (stb[i]) begin
        if (since > 0) begin
          if (since < minh) minh = since;
          if (since > maxh) maxh = since;
        end
        since = 0;
        bits = {bits[W-2:0], ser[i]};
        nb++;
      end
      if (done[i] != 2'b00) begin
        ok = 1; done_v = done[i]; err_v = err[i];
        tick();
        return;
      end
      tick();
      t++;
    end
  endtask

  initial begin
    logic [1:0] g, g2, g3, dv;
    logic [W-1:0] bits, m;
    logic ev;
    int lat, nb, minh, maxh, cnt, t;
    bit ok, seen;

    for (int i = 0; i < N; i++) begin req[i] = 2'b00; mask[i] = $urandom; end
    rst = 1'b1;
    repeat (2) tick();
    check("reset_state", 64'(dut_vec(0)), 64'd0);
    rst = 1'b0;
    tick();

    // Single request from the management core.
    mask[0] = 32'hA5C3_0F81;
    req[0] = 2'b01;
    run_xfer(0, g, lat, bits, nb, minh, maxh, dv, ev, ok);
    req[0] = 2'b00;
    check("single_ok", 64'(ok), 64'd1);
    check("single_gnt", 64'(g), 64'd1);
    check("single_bits", 64'(bits), 64'hA5C3_0F81);
    check("single_nbits", 64'(nb), 64'd32);
    check("single_latency", 64'(lat), 64'd131);
    check("single_done", 64'(dv), 64'd1);
    check("single_err", 64'(ev), 64'd0);
    check("single_id_word", 64'(idw[0]), 64'hA5C3_0F81);

    // Abort after ten bits.
    tick();
    mask[0] = 32'h1234_5678;
    req[0] = 2'b01;
    t = 0;
    while (gnt[0] == 2'b00 && t < 20) begin tick(); t++; end
    cnt = 0; t = 0;
    while (cnt < 11 && t < BOUND) begin tick(); t++; if (stb[0]) cnt++; end
    check("abort_reach", 64'(cnt), 64'd11);
    req[0] = 2'b00;
    tick();
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_gnt", 64'(gnt[0]), 64'd0);
    check("abort_ser", 64'(ser[0]), 64'd0);
    check("abort_id_word", 64'(idw[0]), 64'h1234_5678);
    seen = 0;
    repeat (150) begin tick(); if (done[0] != 2'b00) seen = 1; end
    check("abort_no_done", 64'(seen), 64'd0);

    // Instability: ID changes mid-shift, then a clean readout.
    mask[0] = 32'h1;
    req[0] = 2'b01;
    t = 0;
    while (!stb[0] && t < 20) begin tick(); t++; end
    mask[0] = 32'h3;
    run_xfer(0, g, lat, bits, nb, minh, maxh, dv, ev, ok);
    check("unstable_done", 64'(dv), 64'd1);
    check("unstable_err", 64'(ev), 64'd1);
    run_xfer(0, g, lat, bits, nb, minh, maxh, dv, ev, ok);
    req[0] = 2'b00;
    check("clean_bits", 64'(bits), 64'h3);
    check("clean_done", 64'(dv), 64'd1);
    check("clean_err_sticky", 64'(ev), 64'd1);

    // Reset pulse mid-shift.
    tick();
    mask[0] = $urandom;
    req[0] = 2'b01;
    cnt = 0; t = 0;
    while (cnt < 5 && t < 200) begin tick(); t++; if (stb[0]) cnt++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req[0] = 2'b00;
    check("rst_midshift", 64'(dut_vec(0)), 64'd0);
    seen = 0;
    repeat (200) begin tick(); if (done[0] != 2'b00) seen = 1; end
    check("rst_no_done", 64'(seen), 64'd0);

    // Contention: both requesters held across three transfers.
    req[0] = 2'b11;
    run_xfer(0, g, lat, bits, nb, minh, maxh, dv, ev, ok);
    check("rr_done1", 64'(dv), 64'(g));
    run_xfer(0, g2, lat, bits, nb, minh, maxh, dv, ev, ok);
    check("rr_done2", 64'(dv), 64'(g2));
    run_xfer(0, g3, lat, bits, nb, minh, maxh, dv, ev, ok);
    req[0] = 2'b00;
    check("rr_first", 64'(g), 64'd1);
    check("rr_second", 64'(g2), 64'd2);
    check("rr_third", 64'(g3), 64'd1);

    // Bit hold time and latency at the DIV extremes.
    for (int i = 1; i < N; i++) begin
      m = $urandom;
      mask[i] = m;
      req[i] = 2'b01;
      run_xfer(i, g, lat, bits, nb, minh, maxh, dv, ev, ok);
      req[i] = 2'b00;
      check($sformatf("div%0d_ok", div_of(i)), 64'(ok), 64'd1);
      check($sformatf("div%0d_latency", div_of(i)), 64'(lat), 64'(int'(W) * div_of(i) + 3));
      check($sformatf("div%0d_min_hold", div_of(i)), 64'(minh), 64'(div_of(i)));
      check($sformatf("div%0d_max_hold", div_of(i)), 64'(maxh), 64'(div_of(i)));
      check($sformatf("div%0d_bits", div_of(i)), 64'(bits), 64'(m));
      check($sformatf("div%0d_nbits", div_of(i)), 64'(nb), 64'd32);
    end

    // Randomized traffic on all instances.
    repeat (5000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 149) == 0) req[i] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 399) == 0) mask[i] = $urandom;
      end
      rst = ($urandom_range(0, 1999) == 0);
    end
    rst = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/user_id_reader.md
USER_ID_READER -- requirements
Module: user_id_reader

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning system clocks per serial bit (legal range 2..255).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning ID word width in bits.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports VDD and VSS, inout, 1 bit each, present only under USE_POWER_PINS.
REQ-006 The block SHALL have port mask_rev, input, WIDTH bits: the tie-cell user project ID.
REQ-007 The block SHALL have port req, input, 2 bits: readout requests; bit 0 is the management core, bit 1 is the host SPI.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant.
REQ-009 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-010 The block SHALL have port ser_out, output, 1 bit: serial ID data, MSB first.
REQ-011 The block SHALL have port ser_strobe, output, 1 bit: one-cycle pulse in the first cycle of each bit.
REQ-012 The block SHALL have port done, output, 2 bits: one-cycle completion pulse for the granted requester.
REQ-013 The block SHALL have port id_word, output, WIDTH bits: parallel snapshot of the last captured ID.
REQ-014 The block SHALL have port err, output, 1 bit: sticky ID-instability flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT, CHECK and DONE.
REQ-016 In IDLE with any req bit set, the FSM SHALL grant one requester and go to LOAD in the next cycle.
REQ-017 Arbitration SHALL be round-robin: when both req bits are set, the requester not served last wins; after reset, bit 0 has priority.
REQ-018 gnt SHALL be asserted from LOAD through DONE inclusive and SHALL be zero in IDLE.
REQ-019 In LOAD (one cycle), the block SHALL copy mask_rev into the shift register and into id_word, then go to SHIFT.
REQ-020 In SHIFT, each bit SHALL be held on ser_out for exactly DIV cycles, MSB first; ser_strobe SHALL pulse in the first cycle of each bit; WIDTH bits SHALL take WIDTH*DIV cycles.
REQ-021 After the last bit period, the FSM SHALL go to CHECK (one cycle) and compare mask_rev with id_word; on mismatch it SHALL set err.
REQ-022 DONE SHALL last one cycle, pulse done for the granted bit only, and then return to IDLE.
REQ-023 From grant to the done pulse, latency SHALL be WIDTH*DIV+3 cycles (LOAD + shift + CHECK + DONE).
REQ-024 If the granted req bit drops during LOAD, SHIFT or CHECK, the FSM SHALL abort to IDLE in the next cycle with no done pulse; id_word SHALL keep its captured value.
REQ-025 Requests from the other requester SHALL be ignored until IDLE; a request still held after DONE SHALL be rearbitrated with round-robin priority.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 ser_out SHALL be 0 outside SHIFT.
REQ-028 The bit-period counter width SHALL be ceil(log2(DIV)) bits and SHALL wrap from DIV-1 to 0.
REQ-029 The bit counter SHALL count 0..WIDTH-1 and SHALL not wrap within a transfer.
REQ-030 err SHALL stay set until reset; a later matching readout SHALL not clear it.

Reset
REQ-031 With wb_rst_i high at a clock edge, the FSM SHALL enter IDLE, and gnt, busy, ser_out, ser_strobe, done, err, id_word, the counters and the round-robin pointer SHALL all go to 0.
REQ-032 Reset asserted mid-transfer SHALL take priority over every other event, and no done pulse SHALL be emitted.

Structure
REQ-033 The state encoding and the requester index constants (REQ_MGMT=0, REQ_SPI=1) SHALL live in the shared package user_id_pkg.
REQ-034 The bit-period timer SHALL be one sub-module, user_id_bit_timer, with inputs clear and enable and output tick.
REQ-035 user_id_programming SHALL drive mask_rev at the top level; this block SHALL contain no tie cells.

Verification
REQ-036 Single request, with DIV=4, mask_rev=32'hA5C3_0F81 and req=01: the bench SHALL check gnt=01, bits 1,0,1,0,... at every ser_strobe, done=01 exactly 131 cycles after grant, id_word=32'hA5C3_0F81 and err=0.
REQ-037 Contention, with req=11 held for two transfers: the bench SHALL check grant order 01 then 10, and then 01 again on a third transfer.
REQ-038 Abort, with req[0] dropped after 10 bits: the bench SHALL check IDLE next cycle, busy=0, no done pulse, ser_out=0 and id_word unchanged.
REQ-039 Instability, with mask_rev forced from 32'h1 to 32'h3 during SHIFT: the bench SHALL check err=1 after CHECK, and err still 1 after a later clean readout.
REQ-040 Reset, with wb_rst_i pulsed for 1 cycle mid-SHIFT: the bench SHALL check all outputs 0 the following cycle and no done pulse.
REQ-041 DIV=2 and DIV=255: the bench SHALL check each bit is held exactly DIV cycles and the done latency equals WIDTH*DIV+3.
